// File: rtl/mem_access_stage_if.sv
// Execute -> memory-access -> writeback signals, plus the data-memory req/ack port.
// The master modport is the memory-access stage; the slave modport is its surroundings.
interface mem_access_stage_if;
    logic        ex_valid;
    logic        ex_reg_we;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic [4:0]  ex_wra;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_store_data;

    logic        mem_stall;
    logic        mem_reg_we;
    logic        mem_mem_to_reg;
    logic [4:0]  mem_wra;
    logic [31:0] mem_alu_out;
    logic [31:0] mem_dmem_data;
    logic        mem_misalign;
    logic        mem_bus_err;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        input  ex_valid, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_size, ex_unsigned,
               ex_wra, ex_alu_out, ex_store_data, dm_ack, dm_rdata,
        output mem_stall, mem_reg_we, mem_mem_to_reg, mem_wra, mem_alu_out,
               mem_dmem_data, mem_misalign, mem_bus_err,
               dm_req, dm_we, dm_addr, dm_be, dm_wdata
    );

    modport slave (
        output ex_valid, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_size, ex_unsigned,
               ex_wra, ex_alu_out, ex_store_data, dm_ack, dm_rdata,
        input  mem_stall, mem_reg_we, mem_mem_to_reg, mem_wra, mem_alu_out,
               mem_dmem_data, mem_misalign, mem_bus_err,
               dm_req, dm_we, dm_addr, dm_be, dm_wdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: registers EX results, issues steered loads/stores to data memory.
// Latency: one register stage; a memory access completes in its ack cycle (zero-wait ack possible).
// Backpressure: stalls upstream while req is pending without ack; aborts after TIMEOUT cycles.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rstn,
    mem_access_stage_if.master io
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ABORT} state_t;

    typedef struct packed {
        logic        valid;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  wra;
        logic [31:0] alu_out;
        logic [31:0] store_data;
    } mem_reg_t;

    mem_reg_t      mr;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          is_mem, misaligned, req, stall, timeout_hit;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_ext;
    logic [3:0]    be;
    logic [31:0]   wdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mr <= '0;
        end else if (!stall) begin
            mr.valid      <= io.ex_valid;
            mr.reg_we     <= io.ex_reg_we;
            mr.mem_rd     <= io.ex_mem_rd;
            mr.mem_wr     <= io.ex_mem_wr;
            mr.size       <= io.ex_size;
            mr.uns        <= io.ex_unsigned;
            mr.wra        <= io.ex_wra;
            mr.alu_out    <= io.ex_alu_out;
            mr.store_data <= io.ex_store_data;
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (mr.size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = mr.alu_out[0];
            default: misaligned = |mr.alu_out[1:0];
        endcase
    end

    assign is_mem      = mr.valid & (mr.mem_rd | mr.mem_wr);
    assign req         = is_mem & ~misaligned & (state != ST_ABORT);
    assign stall       = req & ~io.dm_ack;
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    // cnt counts every cycle the current request has gone unacknowledged, including the first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt == ST_WAIT) ? cnt + CW'(1) : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req && !io.dm_ack) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (!req || io.dm_ack) state_nxt = ST_IDLE;
                else if (timeout_hit)  state_nxt = ST_ABORT;
            end
            ST_ABORT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ld_byte = 8'h00;
        case (mr.alu_out[1:0])
            2'd0: ld_byte = io.dm_rdata[7:0];
            2'd1: ld_byte = io.dm_rdata[15:8];
            2'd2: ld_byte = io.dm_rdata[23:16];
            2'd3: ld_byte = io.dm_rdata[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = mr.alu_out[1] ? io.dm_rdata[31:16] : io.dm_rdata[15:0];

        ld_ext = io.dm_rdata;
        be     = 4'b1111;
        wdata  = mr.store_data;
        case (mr.size)
            2'b00: begin
                ld_ext = mr.uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
                be     = 4'b0001 << mr.alu_out[1:0];
                wdata  = {4{mr.store_data[7:0]}};
            end
            2'b01: begin
                ld_ext = mr.uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
                be     = mr.alu_out[1] ? 4'b1100 : 4'b0011;
                wdata  = {2{mr.store_data[15:0]}};
            end
            default: begin
                ld_ext = io.dm_rdata;
                be     = 4'b1111;
                wdata  = mr.store_data;
            end
        endcase

        io.mem_stall      = stall;
        io.mem_reg_we     = mr.valid & mr.reg_we & ~stall & ~(is_mem & misaligned) &
                            (state != ST_ABORT);
        io.mem_mem_to_reg = mr.mem_rd;
        io.mem_wra        = mr.wra;
        io.mem_alu_out    = mr.alu_out;
        io.mem_dmem_data  = (req & ~mr.mem_wr & io.dm_ack) ? ld_ext : 32'h0;
        io.mem_misalign   = is_mem & misaligned;
        io.mem_bus_err    = (state == ST_ABORT);
        io.dm_req         = req;
        io.dm_we          = mr.mem_wr;
        io.dm_addr        = {mr.alu_out[31:2], 2'b00};
        io.dm_be          = be;
        io.dm_wdata       = wdata;
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT=4: loads, stores, misalign, timeout, reset.
module tb_mem_access_stage;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_access_stage_if io();

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .io   (io)
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: observed no finish expected finish before 20000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ex_drive(input logic v, input logic we, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic uns, input logic [4:0] wra,
                            input logic [31:0] alu, input logic [31:0] sd);
        io.ex_valid      = v;
        io.ex_reg_we     = we;
        io.ex_mem_rd     = rd;
        io.ex_mem_wr     = wr;
        io.ex_size       = sz;
        io.ex_unsigned   = uns;
        io.ex_wra        = wra;
        io.ex_alu_out    = alu;
        io.ex_store_data = sd;
    endtask

    task automatic bubble();
        ex_drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Expects an unacked load just loaded into MEM; returns in the abort cycle.
    task automatic expect_timeout(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (io.mem_stall === 1'b1 && n < 10) begin
            n++;
            chk({tag, " reg_we_in_stall"}, io.mem_reg_we, 0);
            @(negedge clk);
        end
        chk({tag, " stall_cycles"}, n, 4);
        chk({tag, " bus_err"}, io.mem_bus_err, 1);
        chk({tag, " reg_we"}, io.mem_reg_we, 0);
        chk({tag, " req"}, io.dm_req, 0);
    endtask

    initial begin
        bubble();
        io.dm_ack   = 1'b0;
        io.dm_rdata = 32'h0;

        #12;
        chk("rst req", io.dm_req, 0);
        chk("rst stall", io.mem_stall, 0);
        chk("rst reg_we", io.mem_reg_we, 0);
        chk("rst bus_err", io.mem_bus_err, 0);
        chk("rst misalign", io.mem_misalign, 0);
        chk("rst addr", io.dm_addr, 0);
        chk("rst dmem", io.mem_dmem_data, 0);
        @(negedge clk);
        rstn = 1'b1;

        // zero-wait LW
        ex_drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 5'd5, 32'h100, 32'h0);
        tick();
        bubble();
        io.dm_ack   = 1'b1;
        io.dm_rdata = 32'hDEADBEEF;
        settle();
        chk("lw req", io.dm_req, 1);
        chk("lw addr", io.dm_addr, 32'h100);
        chk("lw we", io.dm_we, 0);
        chk("lw be", io.dm_be, 4'b1111);
        chk("lw stall", io.mem_stall, 0);
        chk("lw reg_we", io.mem_reg_we, 1);
        chk("lw m2r", io.mem_mem_to_reg, 1);
        chk("lw wra", io.mem_wra, 5);
        chk("lw dmem", io.mem_dmem_data, 32'hDEADBEEF);
        tick();
        io.dm_ack = 1'b0;

        // LB signed with 3 wait cycles; a following ALU op must be held
        ex_drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 5'd7, 32'h103, 32'h0);
        tick();
        ex_drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 5'd9, 32'h55, 32'h0);
        settle();
        chk("lb be", io.dm_be, 4'b1000);
        chk("lb addr", io.dm_addr, 32'h100);
        chk("lb dmem_no_ack", io.mem_dmem_data, 0);
        for (int c = 0; c < 3; c++) begin
            chk("lb stall", io.mem_stall, 1);
            chk("lb reg_we_stall", io.mem_reg_we, 0);
            tick();
            settle();
        end
        io.dm_ack   = 1'b1;
        io.dm_rdata = 32'h80112233;
        #1;
        chk("lb ack stall", io.mem_stall, 0);
        chk("lb ack reg_we", io.mem_reg_we, 1);
        chk("lb ack wra", io.mem_wra, 7);
        chk("lb dmem", io.mem_dmem_data, 32'hFFFFFF80);
        tick();
        io.dm_ack = 1'b0;
        bubble();
        settle();
        chk("alu held wra", io.mem_wra, 9);
        chk("alu held out", io.mem_alu_out, 32'h55);
        chk("alu reg_we", io.mem_reg_we, 1);
        chk("alu req", io.dm_req, 0);
        chk("alu m2r", io.mem_mem_to_reg, 0);

        // SH
        ex_drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 5'd0, 32'h102, 32'h0000ABCD);
        tick();
        bubble();
        settle();
        chk("sh req", io.dm_req, 1);
        chk("sh we", io.dm_we, 1);
        chk("sh be", io.dm_be, 4'b1100);
        chk("sh wdata", io.dm_wdata, 32'hABCDABCD);
        chk("sh addr", io.dm_addr, 32'h100);
        chk("sh stall", io.mem_stall, 1);
        chk("sh reg_we", io.mem_reg_we, 0);
        io.dm_ack = 1'b1;
        #1;
        chk("sh ack stall", io.mem_stall, 0);
        chk("sh ack reg_we", io.mem_reg_we, 0);
        tick();
        io.dm_ack = 1'b0;

        // SB lane 1
        ex_drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0, 32'h101, 32'h1234565A);
        tick();
        bubble();
        io.dm_ack = 1'b1;
        settle();
        chk("sb be", io.dm_be, 4'b0010);
        chk("sb wdata", io.dm_wdata, 32'h5A5A5A5A);
        chk("sb stall", io.mem_stall, 0);
        tick();
        io.dm_ack = 1'b0;

        // LHU upper half
        ex_drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 5'd12, 32'h102, 32'h0);
        tick();
        bubble();
        io.dm_ack   = 1'b1;
        io.dm_rdata = 32'h80011234;
        settle();
        chk("lhu be", io.dm_be, 4'b1100);
        chk("lhu dmem", io.mem_dmem_data, 32'h00008001);
        chk("lhu reg_we", io.mem_reg_we, 1);
        tick();
        io.dm_ack = 1'b0;

        // misaligned LW
        ex_drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 5'd4, 32'h101, 32'h0);
        tick();
        bubble();
        settle();
        chk("mis req", io.dm_req, 0);
        chk("mis pulse", io.mem_misalign, 1);
        chk("mis reg_we", io.mem_reg_we, 0);
        chk("mis stall", io.mem_stall, 0);
        tick();
        settle();
        chk("mis pulse_end", io.mem_misalign, 0);

        // timeout, then the held ALU op retires
        ex_drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 5'd3, 32'h200, 32'h0);
        tick();
        ex_drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 5'd10, 32'h77, 32'h0);
        expect_timeout("to1");
        tick();
        bubble();
        settle();
        chk("to1 bus_err_end", io.mem_bus_err, 0);
        chk("to1 next reg_we", io.mem_reg_we, 1);
        chk("to1 next wra", io.mem_wra, 10);
        chk("to1 next alu", io.mem_alu_out, 32'h77);

        // async reset while waiting
        ex_drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 5'd6, 32'h300, 32'h0);
        tick();
        bubble();
        settle();
        chk("rw stall0", io.mem_stall, 1);
        tick();
        settle();
        chk("rw stall1", io.mem_stall, 1);
        #1;
        rstn = 1'b0;
        #1;
        chk("rw req", io.dm_req, 0);
        chk("rw stall", io.mem_stall, 0);
        chk("rw reg_we", io.mem_reg_we, 0);
        chk("rw addr", io.dm_addr, 0);
        chk("rw alu", io.mem_alu_out, 0);
        chk("rw wra", io.mem_wra, 0);
        chk("rw bus_err", io.mem_bus_err, 0);
        @(negedge clk);
        rstn = 1'b1;

        // a fresh unacked load must take the full timeout again
        ex_drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 5'd8, 32'h304, 32'h0);
        tick();
        bubble();
        expect_timeout("to2");
        tick();
        settle();
        chk("to2 bus_err_end", io.mem_bus_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
